dip_note_selector: RTL
======================

// Module: dip_note_selector
// PURPOSE
//  Upstream front end for the tone player. Synchronises and debounces the eight
//  DIP switches and classifies the stable setting as one note, silence or invalid.
//  Each change of setting is offered once to the tone player over a valid/ready
//  handshake, so the player only ever sees clean, one-hot or zero note codes.
// PARAMETERS
//  DB_CYCLES  1_000_000  consecutive stable clk cycles required to accept a switch value (10 ms @ 100 MHz); must be >= 2
// PORTS
//  clk           in   1  system clock, 100 MHz
//  rst           in   1  synchronous reset, active-high
//  dip_switches  in   8  raw asynchronous switch inputs, bit0=C4 .. bit7=C5
//  note_onehot   out  8  offered note: one-hot, or 0 for silence or invalid
//  note_index    out  3  binary index of the set bit of note_onehot; 0 when note_onehot==0
//  note_invalid  out  1  offered payload came from a multi-bit switch setting
//  note_valid    out  1  payload is offered
//  note_ready    in   1  consumer accepts the payload when note_valid && note_ready
// BEHAVIOUR
//  Synchroniser: 2-flop chain s1 -> s2 on all 8 bits; no logic between the flops.
//  Debounce, using registers cand[7:0] and cnt (width clog2(DB_CYCLES)):
//   - s2 != cand: cand <= s2, cnt <= 0.
//   - else if cnt == DB_CYCLES-1: stable <= cand; cnt holds (saturates).
//   - else: cnt <= cnt + 1.
//  Classify stable, combinationally:
//   - zero bits set: silence. Payload = {0, 8'h00}.
//   - exactly one bit set: note. Payload = {0, stable}.
//   - two or more bits set: invalid. Payload = {1, 8'h00}.
//  Output FSM, states IDLE and OFFER:
//   - IDLE: if payload != last_sent, latch payload into the output registers and
//     go to OFFER. note_valid is 1 from the next cycle.
//   - OFFER: note_onehot, note_index and note_invalid are frozen.
//     On note_valid && note_ready: last_sent <= offered payload, go to IDLE, note_valid <= 0.
//   - The payload may change several times during OFFER. Only the value present
//     after acceptance is compared in IDLE: latest wins, intermediate values are dropped.
//   - After an accept, note_valid is low for at least 1 cycle before the next offer.
//   - Back-to-back identical payloads are never re-offered.
//  Latency: let edge N be the first edge that samples a new held switch value.
//  stable updates at edge N+DB_CYCLES+2. note_valid is high after edge N+DB_CYCLES+3,
//  provided the FSM is in IDLE.
//  Glitch rule: any s2 change before cnt saturates restarts the count.
//  A glitch of 1..DB_CYCLES-1 cycles never changes stable.
//  Reset values: s1, s2, cand, cnt and stable = 0; last_sent = {0, 8'h00} (silence); state = IDLE;
//  note_onehot = 0, note_index = 0, note_invalid = 0, note_valid = 0.
//  Because last_sent resets to silence, no offer is made after reset while the switches are all 0.
//  Reset asserted mid-OFFER drops the pending offer, and note_valid is 0 after that edge.
//  rst has priority over every other condition in the same cycle.
//  note_index encoding: bit k set gives index k, for example 8'b0010_0000 -> 3'd5.
// TESTING (DB_CYCLES=4)
//  1. Reset, switches 0, ready=1, run 50 cycles -> note_valid never asserts and all outputs stay 0.
//  2. Set 8'h01 at edge 0 with ready=1 -> note_valid high after edge 7 with onehot=01, index=0;
//     low after edge 8.
//  3. Hold 8'h04, then pulse 8'h00 for 3 cycles -> no new offer; stable stays 04.
//  4. ready=0; change 8'h10 -> 8'h20 -> 8'h80, each held 20 cycles; then ready=1 ->
//     exactly two accepts: 10 (frozen through all changes) then 80; 20 is never offered.
//  5. Set 8'h03 -> one offer with invalid=1, onehot=0; then 8'h00 -> one offer with
//     invalid=0, onehot=0.
//  6. Assert rst for 1 cycle during OFFER with 8'h40 held -> valid low the next cycle;
//     8'h40 is re-offered DB_CYCLES+3 edges after rst falls.

Source files
------------

// File: rtl/dip_note_selector.sv
// DIP switch front end: synchronise, debounce and classify eight switches, then
// offer each new note/silence/invalid setting once over a valid/ready handshake.
module dip_note_selector #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dip_switches,
    output logic [7:0] note_onehot,
    output logic [2:0] note_index,
    output logic       note_invalid,
    output logic       note_valid,
    input  logic       note_ready
);

    localparam int CW = $clog2(DB_CYCLES);

    // Handshake: a payload is transferred on every clk edge where note_valid && note_ready;
    // while note_valid is high the payload outputs are frozen and note_valid never drops
    // before that transfer (except on rst).
    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t         state;
    logic [7:0]     s1;
    logic [7:0]     s2;
    logic [7:0]     cand;
    logic [CW-1:0]  cnt;
    logic [7:0]     stable;
    logic [8:0]     last_sent;
    logic [3:0]     ones;
    logic [8:0]     payload;
    logic [2:0]     payload_index;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            s1 <= dip_switches;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                stable <= cand;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Multi-bit settings collapse to a single invalid code so the player never sees chords.
    always_comb begin
        ones = '0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'b000, stable[i]};
        end
        payload = '0;
        if (ones == 4'd1) begin
            payload = {1'b0, stable};
        end else if (ones > 4'd1) begin
            payload = {1'b1, 8'h00};
        end
    end

    always_comb begin
        payload_index = '0;
        for (int i = 0; i < 8; i++) begin
            if (payload[i]) begin
                payload_index = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_sent    <= '0;
            note_onehot  <= '0;
            note_index   <= '0;
            note_invalid <= 1'b0;
            note_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (payload != last_sent) begin
                        note_onehot  <= payload[7:0];
                        note_index   <= payload_index;
                        note_invalid <= payload[8];
                        note_valid   <= 1'b1;
                        state        <= OFFER;
                    end
                end
                OFFER: begin
                    // Only the value present after acceptance is compared next, so
                    // intermediate settings seen while waiting are dropped.
                    if (note_valid && note_ready) begin
                        last_sent  <= {note_invalid, note_onehot};
                        note_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
